yarp_lsu: RTL and testbench

Load/store unit for the yarp RV32I core. Sits directly downstream of the decode/control stage: consumes the memory fields of the control word (`data_req`, `data_wr`, `data_byte`, `zero_extnd`) together with the ALU-computed address and rs2 data. It runs a req/gnt/rvalid handshake to the data memory, stalls the core while a transfer is in flight, and returns a size-aligned, sign- or zero-extended load result to the register-file write-back mux (the MEM source).

---
 rtl/yarp_lsu.sv | 122 ++++++++++++
 tb/tb_yarp_lsu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/yarp_lsu.sv
// yarp_lsu: load/store unit driving a req/gnt/rvalid data-memory handshake
module yarp_lsu #(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req_i,
    input  logic        lsu_wr_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_zero_extnd_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_stall_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic        lsu_misalign_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state;
    logic [1:0]  size_q;
    logic        zext_q;
    logic [1:0]  a_q;
    logic [9:0]  cnt;
    logic        misaligned;
    logic        accept;
    logic        timeout;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    // request decode: alignment, lane enables and replicated store data
    always_comb begin
        misaligned = (lsu_size_i == 2'b01 && lsu_addr_i[0]) || (lsu_size_i[1] && lsu_addr_i[1:0] != 2'b00);
        accept = state == IDLE && lsu_req_i && !misaligned;
        lsu_misalign_o = state == IDLE && lsu_req_i && misaligned;
        lsu_stall_o = accept || state == REQ || state == WAIT;
        timeout = cnt == 10'(RSP_TIMEOUT - 1);
        be_n = lsu_size_i == 2'b00 ? 4'b0001 << lsu_addr_i[1:0] :
               lsu_size_i == 2'b01 ? 4'b0011 << {lsu_addr_i[1], 1'b0} : 4'hF;
        wdata_n = lsu_size_i == 2'b00 ? {4{lsu_wdata_i[7:0]}} :
                  lsu_size_i == 2'b01 ? {2{lsu_wdata_i[15:0]}} : lsu_wdata_i;
    end
    // load lane extraction and sign/zero extension from the latched request
    always_comb begin
        byte_sel = mem_rdata_i[8*a_q +: 8];
        half_sel = a_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_ext = size_q == 2'b00 ? {{24{!zext_q && byte_sel[7]}}, byte_sel} :
                   size_q == 2'b01 ? {{16{!zext_q && half_sel[15]}}, half_sel} : mem_rdata_i;
    end
    // handshake FSM with registered bus and completion outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            size_q      <= 2'b00;
            zext_q      <= 1'b0;
            a_q         <= 2'b00;
            cnt         <= 10'd0;
            lsu_done_o  <= 1'b0;
            lsu_err_o   <= 1'b0;
            lsu_rdata_o <= 32'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= 32'd0;
        end else begin
            lsu_done_o <= 1'b0;
            lsu_err_o  <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state       <= REQ;
                    mem_req_o   <= 1'b1;
                    mem_we_o    <= lsu_wr_i;
                    mem_addr_o  <= {lsu_addr_i[31:2], 2'b00};
                    mem_be_o    <= be_n;
                    mem_wdata_o <= wdata_n;
                    size_q      <= lsu_size_i;
                    zext_q      <= lsu_zero_extnd_i;
                    a_q         <= lsu_addr_i[1:0];
                    cnt         <= 10'd0;
                end
                REQ: begin
                    cnt <= cnt + 10'd1;
                    if (mem_gnt_i) begin
                        state     <= WAIT;
                        mem_req_o <= 1'b0;
                    end else if (timeout) begin
                        state       <= DONE;
                        mem_req_o   <= 1'b0;
                        lsu_done_o  <= 1'b1;
                        lsu_err_o   <= 1'b1;
                        lsu_rdata_o <= 32'd0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 10'd1;
                    if (mem_rvalid_i) begin
                        state      <= DONE;
                        lsu_done_o <= 1'b1;
                        if (!mem_we_o) lsu_rdata_o <= load_ext;
                    end else if (timeout) begin
                        state       <= DONE;
                        lsu_done_o  <= 1'b1;
                        lsu_err_o   <= 1'b1;
                        lsu_rdata_o <= 32'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_yarp_lsu.sv
// tb_yarp_lsu: directed checks of the load/store unit handshake and data paths
module tb_yarp_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_wr_i = 1'b0;
    logic [1:0]  lsu_size_i = 2'b00;
    logic        lsu_zero_extnd_i = 1'b0;
    logic [31:0] lsu_addr_i = 32'd0;
    logic [31:0] lsu_wdata_i = 32'd0;
    logic        lsu_stall_o, lsu_done_o, lsu_err_o, lsu_misalign_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;

    int n_chk = 0;
    int n_fail = 0;
    int done_at, reqs, stalls;
    logic        err_seen, we_seen, stall_at_done, flag;
    logic [31:0] rd_seen, addr_seen, wd_seen;
    logic [3:0]  be_seen;

    yarp_lsu #(.RSP_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .lsu_req_i(lsu_req_i), .lsu_wr_i(lsu_wr_i), .lsu_size_i(lsu_size_i),
        .lsu_zero_extnd_i(lsu_zero_extnd_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o),
        .lsu_misalign_o(lsu_misalign_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drives one transfer from IDLE; memory grants after gnt_dly extra request
    // cycles and answers the cycle after the grant when give_rv is set.
    task automatic run_op(input logic wr, input logic [1:0] sz, input logic zx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int gnt_dly, input logic give_rv);
        int cyc = 0;
        logic granted = 1'b0;
        logic rv_sent = 1'b0;
        done_at = -1; reqs = 0; stalls = 0;
        @(negedge clk);
        lsu_req_i = 1'b1; lsu_wr_i = wr; lsu_size_i = sz; lsu_zero_extnd_i = zx;
        lsu_addr_i = addr; lsu_wdata_i = wd; mem_rdata_i = rd;
        while (done_at < 0 && cyc < 40) begin
            if (lsu_done_o) begin
                done_at = cyc; err_seen = lsu_err_o; rd_seen = lsu_rdata_o;
                stall_at_done = lsu_stall_o;
            end else begin
                if (mem_req_o) begin
                    reqs++;
                    be_seen = mem_be_o; addr_seen = mem_addr_o; wd_seen = mem_wdata_o; we_seen = mem_we_o;
                end
                mem_gnt_i = mem_req_o && reqs == gnt_dly + 1;
                mem_rvalid_i = give_rv && granted && !rv_sent;
                if (mem_rvalid_i) rv_sent = 1'b1;
                granted = granted | mem_gnt_i;
                #1;
                if (lsu_stall_o) stalls++;
                cyc++;
                @(negedge clk);
            end
        end
        check("op_completed", 32'(done_at >= 0), 32'd1);
        @(negedge clk);
        lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        check("post_done_no_req", 32'(mem_req_o), 32'd0);
        check("post_done_no_stall", 32'(lsu_stall_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_rdata", lsu_rdata_o, 32'd0);
        check("rst_done", 32'(lsu_done_o), 32'd0);
        check("rst_err", 32'(lsu_err_o), 32'd0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        check("rst_stall", 32'(lsu_stall_o), 32'd0);
        reset = 1'b0;

        run_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1);
        check("lw_be", 32'(be_seen), 32'hF);
        check("lw_addr", addr_seen, 32'h100);
        check("lw_we", 32'(we_seen), 32'd0);
        check("lw_rdata", rd_seen, 32'hDEADBEEF);
        check("lw_latency", 32'(done_at), 32'd3);
        check("lw_stalls", 32'(stalls), 32'd3);
        check("lw_stall_in_done", 32'(stall_at_done), 32'd0);
        check("lw_err", 32'(err_seen), 32'd0);

        run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80AA5511, 0, 1'b1);
        check("lb_be", 32'(be_seen), 32'h8);
        check("lb_addr", addr_seen, 32'h100);
        check("lb_sext", rd_seen, 32'hFFFFFF80);
        run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80AA5511, 0, 1'b1);
        check("lbu_zext", rd_seen, 32'h00000080);
        run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80AA5511, 1, 1'b1);
        check("lh_be", 32'(be_seen), 32'hC);
        check("lh_sext", rd_seen, 32'hFFFF80AA);
        check("lh_latency", 32'(done_at), 32'd4);
        run_op(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h80AA5511, 0, 1'b1);
        check("lhu_low", rd_seen, 32'h00005511);
        run_op(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h80AA5511, 0, 1'b1);
        check("lbu_lane1", rd_seen, 32'h00000055);

        run_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 4, 1'b1);
        check("sh_req_cycles", 32'(reqs), 32'd5);
        check("sh_be", 32'(be_seen), 32'hC);
        check("sh_wdata", wd_seen, 32'hABCDABCD);
        check("sh_we", 32'(we_seen), 32'd1);
        check("sh_addr", addr_seen, 32'h200);
        check("sh_rdata_held", rd_seen, 32'h00000055);

        run_op(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5, 32'h0, 0, 1'b1);
        check("sb_be", 32'(be_seen), 32'h2);
        check("sb_wdata", wd_seen, 32'hA5A5A5A5);

        @(negedge clk);
        lsu_req_i = 1'b1; lsu_wr_i = 1'b0; lsu_size_i = 2'b11; lsu_addr_i = 32'h101;
        #1;
        check("mis_flag", 32'(lsu_misalign_o), 32'd1);
        check("mis_stall", 32'(lsu_stall_o), 32'd0);
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            flag = flag | mem_req_o | lsu_done_o;
        end
        check("mis_no_bus", 32'(flag), 32'd0);
        lsu_size_i = 2'b01; lsu_addr_i = 32'h203;
        #1;
        check("mis_half", 32'(lsu_misalign_o), 32'd1);
        lsu_addr_i = 32'h202;
        #1;
        check("half_aligned", 32'(lsu_misalign_o), 32'd0);
        lsu_req_i = 1'b0;

        run_op(1'b0, 2'b11, 1'b0, 32'h500, 32'h0, 32'h12345678, 0, 1'b0);
        check("to_err", 32'(err_seen), 32'd1);
        check("to_rdata", rd_seen, 32'd0);
        check("to_latency", 32'(done_at), 32'd9);
        @(negedge clk);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        check("stray_no_done", 32'(lsu_done_o), 32'd0);
        check("stray_rdata", lsu_rdata_o, 32'd0);

        @(negedge clk);
        lsu_req_i = 1'b1; lsu_wr_i = 1'b1; lsu_size_i = 2'b11; lsu_addr_i = 32'h400; lsu_wdata_i = 32'hCAFE0001;
        @(negedge clk);
        check("rst_req_up", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_wait_req", 32'(mem_req_o), 32'd0);
        check("rst_wait_we", 32'(mem_we_o), 32'd0);
        check("rst_wait_be", 32'(mem_be_o), 32'd0);
        lsu_req_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem_rvalid_i = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            flag = flag | lsu_done_o | mem_req_o;
        end
        check("rst_no_done", 32'(flag), 32'd0);
        run_op(1'b0, 2'b11, 1'b0, 32'h600, 32'h0, 32'h0BADF00D, 0, 1'b1);
        check("post_rst_rdata", rd_seen, 32'h0BADF00D);
        check("post_rst_latency", 32'(done_at), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
